// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtract per cycle; the borrow of that subtract decides each quotient bit.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             want_rem,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             quot_neg_q;
  logic             rem_neg_q;
  logic             want_rem_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;
  logic             ovf_q;

  logic             dvd_neg_d;
  logic             dvs_neg_d;
  logic [WIDTH-1:0] dvd_abs_d;
  logic [WIDTH-1:0] dvs_abs_d;
  logic             is_zero_d;
  logic             is_ovf_d;
  logic [WIDTH-1:0] rem_sh_d;
  logic [WIDTH:0]   diff_d;
  logic             no_borrow_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  // Operand magnitudes, special-case detection and the per-iteration trial subtract
  always_comb begin
    dvd_neg_d   = is_signed & dividend[WIDTH-1];
    dvs_neg_d   = is_signed & divisor[WIDTH-1];
    dvd_abs_d   = dvd_neg_d ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
    dvs_abs_d   = dvs_neg_d ? (~divisor + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;
    is_zero_d   = (divisor == {WIDTH{1'b0}});
    is_ovf_d    = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                  && (divisor == {WIDTH{1'b1}});
    // The partial remainder is always below 2^(iterations done), so dropping its MSB loses nothing
    rem_sh_d    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    diff_d      = {1'b0, rem_sh_d} + {1'b0, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    no_borrow_d = diff_d[WIDTH];
    quo_fix_d   = quot_neg_q ? (~quo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_q;
    rem_fix_d   = rem_neg_q ? (~rem_q + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q;
  end

  // Control FSM, datapath registers and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      want_rem_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            want_rem_q  <= want_rem;
            if (is_zero_d) begin
              result_q    <= want_rem ? dividend : {WIDTH{1'b1}};
              dbz_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (is_ovf_d) begin
              result_q    <= want_rem ? {WIDTH{1'b0}} : dividend;
              ovf_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q      <= {WIDTH{1'b0}};
              quo_q      <= dvd_abs_d;
              dvs_q      <= dvs_abs_d;
              quot_neg_q <= dvd_neg_d ^ dvs_neg_d;
              rem_neg_q  <= dvd_neg_d;
              cnt_q      <= CW'(WIDTH);
              state_q    <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= no_borrow_d ? diff_d[WIDTH-1:0] : rem_sh_d;
          quo_q <= {quo_q[WIDTH-2:0], no_borrow_d};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q    <= want_rem_q ? rem_fix_d : quo_fix_d;
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider: arithmetic, special cases,
// latency, backpressure and reset during an operation.
module tb_iterative_divider;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        want_rem;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;
  logic        div_by_zero;
  logic        overflow;

  int n_checks;
  int n_pass;

  iterative_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .is_signed  (is_signed),
    .want_rem   (want_rem),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .result     (result),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one request (rsp_ready held high) and check result, flags and latency
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic rem, input logic [31:0] exp_res,
                       input logic exp_dbz, input logic exp_ovf, input int exp_lat);
    int lat;
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    want_rem  = rem;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0000_0003;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    @(posedge clk);
    #1;
    chk({tag, ".rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    is_signed = 1'b0;
    want_rem  = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.flags", {30'd0, div_by_zero, overflow}, 32'd0);

    do_op("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_000E, 1'b0, 1'b0, 34);
    do_op("remu_100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 34);
    do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0, 34);
    do_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);
    do_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0, 34);
    do_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 34);
    do_op("div_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 34);
    do_op("remu_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, 32'h7FFF_FFFE, 1'b0, 1'b0, 34);
    do_op("div_5_0", 32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
    do_op("remu_5_0", 32'd5, 32'd0, 1'b0, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1);
    do_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1);
    do_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1);
    do_op("divu_ovfops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 34);
    do_op("remu_ovfops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 34);

    // Backpressure: divide-by-zero response held for 10 cycles while new requests knock
    rsp_ready = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd0;
    is_signed = 1'b0;
    want_rem  = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("bp.valid", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      dividend  = 32'd100 + 32'(i);
      divisor   = 32'd3;
      req_valid = i[0];
      @(posedge clk);
      #1;
      chk("bp.hold_result", result, 32'd9);
      chk("bp.hold_flags", {30'd0, div_by_zero, overflow}, 32'd2);
      chk("bp.req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp.release_ready", {31'd0, req_ready}, 32'd1);
    chk("bp.release_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp.still_idle", {31'd0, req_ready}, 32'd1);

    // Reset during BUSY iteration 10, then a fresh request completes normally
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'd1;
    is_signed = 1'b0;
    want_rem  = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst.result", result, 32'd0);
    do_op("post_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
